// File: rtl/spc700_muldiv_pkg.sv
// Shared enums, fixed latencies and result payload for the SPC700 MUL/DIV unit.
package spc700;

  typedef enum logic {
    MULDIV_MUL = 1'b0,
    MULDIV_DIV = 1'b1
  } MulDivOp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

  localparam int unsigned MUL_CYCLES = 8;
  localparam int unsigned DIV_CYCLES = 11;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned REM_W      = 17;
  localparam int unsigned DSR_W      = 9;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] a;
    logic       z;
    logic       s;
    logic       v;
    logic       h;
  } muldiv_res_t;

  localparam muldiv_res_t RES_RESET = '{y: 8'h00, a: 8'h00, z: 1'b1, s: 1'b0, v: 1'b0, h: 1'b0};

  // Attach the flag set to a finished result; DIV flags look at the operands, MUL only at Y.
  function automatic muldiv_res_t make_res(input MulDivOp_t op, input logic [7:0] y,
                                           input logic [7:0] a, input logic [7:0] opy,
                                           input logic [7:0] opx);
    muldiv_res_t r;
    r.y = y;
    r.a = a;
    if (op == MULDIV_MUL) begin
      r.z = (y == 8'h00);
      r.s = y[7];
      r.v = 1'b0;
      r.h = 1'b0;
    end else begin
      r.z = (a == 8'h00);
      r.s = a[7];
      r.v = (opy >= opx);
      r.h = (opy[3:0] >= opx[3:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/spc700_muldiv_div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module spc700_div_step
  import spc700::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  input  logic [DSR_W-1:0] i_dsr,
  output logic [REM_W-1:0] o_rem_c,
  output logic             o_q_c
);

  logic [REM_W:0] w_shift;

  always_comb begin
    w_shift = {i_rem, i_bit};
    o_q_c   = (w_shift >= (REM_W+1)'(i_dsr));
    o_rem_c = o_q_c ? REM_W'(w_shift - (REM_W+1)'(i_dsr)) : w_shift[REM_W-1:0];
  end

endmodule

// File: rtl/spc700_muldiv.sv
// SPC700 MUL YA / DIV YA,X unit with clock enable; iterative by default.
// Define SPC700_MULDIV_FAST_EN for a one-cycle RUN with combinational results.
module spc700_muldiv
  import spc700::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       START,
  input  logic       OP,
  input  logic [7:0] Y_IN,
  input  logic [7:0] A_IN,
  input  logic [7:0] X_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] Y_OUT,
  output logic [7:0] A_OUT,
  output logic       ZO,
  output logic       SO,
  output logic       VO,
  output logic       HO
);

  muldiv_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  MulDivOp_t        r_op,    w_op_nxt;
  logic [7:0]       r_y,     w_y_nxt;
  logic [7:0]       r_a,     w_a_nxt;
  logic [7:0]       r_x,     w_x_nxt;
  logic [15:0]      r_prod,  w_prod_nxt;
  logic [REM_W-1:0] r_rem,   w_rem_nxt;
  logic [8:0]       r_dvd,   w_dvd_nxt;
  logic [7:0]       r_quo,   w_quo_nxt;
  logic [DSR_W-1:0] r_dsr,   w_dsr_nxt;
  logic             r_big,   w_big_nxt;
  muldiv_res_t      r_res,   w_res_nxt;
  logic             r_busy,  r_done;

  logic [15:0]      w_ya;
  logic [15:0]      w_n;
  logic             w_big;
  logic [DSR_W-1:0] w_dsr;
  logic [8:0]       w_mul_sum;
  logic [15:0]      w_mul_step;
  logic [15:0]      w_mul_res;
  logic [REM_W-1:0] w_step_rem;
  logic             w_step_q;
  logic [7:0]       w_div_q;
  logic [7:0]       w_div_r;
  logic             w_div_big;
  logic [7:0]       w_div_a;
  logic [7:0]       w_div_y;

  // Y >= 2X selects the overflow formula: divide (YA - 512X) by (256 - X) instead of YA by X.
  assign w_ya  = {r_y, r_a};
  assign w_big = ({1'b0, r_y} >= {r_x, 1'b0});
  assign w_n   = w_big ? (w_ya - {r_x[6:0], 9'h000}) : w_ya;
  assign w_dsr = w_big ? (9'h100 - {1'b0, r_x}) : {1'b0, r_x};

  assign w_mul_sum  = {1'b0, r_prod[15:8]} + (r_prod[0] ? {1'b0, r_y} : 9'h000);
  assign w_mul_step = {w_mul_sum, r_prod[7:1]};

  spc700_div_step u_div_step (
    .i_rem   (r_rem),
    .i_bit   (r_dvd[8]),
    .i_dsr   (r_dsr),
    .o_rem_c (w_step_rem),
    .o_q_c   (w_step_q)
  );

`ifdef SPC700_MULDIV_FAST_EN
  assign w_mul_res = 16'(r_y) * 16'(r_a);
  assign w_div_q   = 8'(w_n / 16'(w_dsr));
  assign w_div_r   = 8'(w_n % 16'(w_dsr));
  assign w_div_big = w_big;
`else
  assign w_mul_res = w_mul_step;
  assign w_div_q   = r_quo;
  assign w_div_r   = r_rem[7:0];
  assign w_div_big = r_big;
`endif

  // 255 - q truncated to 8 bits is the bitwise complement of q's low byte.
  assign w_div_a = w_div_big ? ~w_div_q : w_div_q;
  assign w_div_y = w_div_big ? (r_x + w_div_r) : w_div_r;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_y_nxt     = r_y;
    w_a_nxt     = r_a;
    w_x_nxt     = r_x;
    w_prod_nxt  = r_prod;
    w_rem_nxt   = r_rem;
    w_dvd_nxt   = r_dvd;
    w_quo_nxt   = r_quo;
    w_dsr_nxt   = r_dsr;
    w_big_nxt   = r_big;
    w_res_nxt   = r_res;
    if (EN) begin
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            w_state_nxt = S_RUN;
            w_op_nxt    = MulDivOp_t'(OP);
            w_y_nxt     = Y_IN;
            w_a_nxt     = A_IN;
            w_x_nxt     = X_IN;
            w_prod_nxt  = {8'h00, A_IN};
`ifdef SPC700_MULDIV_FAST_EN
            w_cnt_nxt   = CNT_W'(1);
`else
            w_cnt_nxt   = OP ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
`endif
          end
        end
        S_RUN: begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
`ifndef SPC700_MULDIV_FAST_EN
          // DIV schedule: first count sets up, nine counts each yield a quotient bit, last one finalises.
          if (r_op == MULDIV_MUL) begin
            w_prod_nxt = w_mul_step;
          end else if (r_cnt == CNT_W'(DIV_CYCLES)) begin
            w_rem_nxt = {10'h000, w_n[15:9]};
            w_dvd_nxt = w_n[8:0];
            w_quo_nxt = 8'h00;
            w_dsr_nxt = w_dsr;
            w_big_nxt = w_big;
          end else if (r_cnt != CNT_W'(1)) begin
            w_rem_nxt = w_step_rem;
            w_dvd_nxt = {r_dvd[7:0], 1'b0};
            w_quo_nxt = {r_quo[6:0], w_step_q};
          end
`endif
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
            if (r_op == MULDIV_MUL) begin
              w_res_nxt = make_res(MULDIV_MUL, w_mul_res[15:8], w_mul_res[7:0], r_y, r_x);
            end else begin
              w_res_nxt = make_res(MULDIV_DIV, w_div_y, w_div_a, r_y, r_x);
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= MULDIV_MUL;
      r_y     <= 8'h00;
      r_a     <= 8'h00;
      r_x     <= 8'h00;
      r_prod  <= 16'h0000;
      r_rem   <= '0;
      r_dvd   <= 9'h000;
      r_quo   <= 8'h00;
      r_dsr   <= '0;
      r_big   <= 1'b0;
      r_res   <= RES_RESET;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_y     <= w_y_nxt;
      r_a     <= w_a_nxt;
      r_x     <= w_x_nxt;
      r_prod  <= w_prod_nxt;
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_dvd_nxt;
      r_quo   <= w_quo_nxt;
      r_dsr   <= w_dsr_nxt;
      r_big   <= w_big_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign Y_OUT = r_res.y;
  assign A_OUT = r_res.a;
  assign ZO    = r_res.z;
  assign SO    = r_res.s;
  assign VO    = r_res.v;
  assign HO    = r_res.h;

endmodule

// File: doc/spc700_muldiv.md
SPC700_MULDIV -- requirements
Module: spc700_muldiv

Interface
REQ-001 SHALL have parameters: none; latencies are fixed constants in the spc700 package.
REQ-002 SHALL have port CLK  in  1  clock.
REQ-003 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port EN  in  1  clock enable; state advances only when high.
REQ-005 SHALL have port START  in  1  request a new operation, sampled when EN=1.
REQ-006 SHALL have port OP  in  1  0=MUL YA, 1=DIV YA,X.
REQ-007 SHALL have ports Y_IN, A_IN, X_IN  in  8 each  operand registers.
REQ-008 SHALL have port BUSY  out  1  operation in progress.
REQ-009 SHALL have port DONE  out  1  one-EN-cycle pulse when the result is valid.
REQ-010 SHALL have ports Y_OUT, A_OUT  out  8 each  result bytes, held until the next accepted START.
REQ-011 SHALL have ports ZO, SO, VO, HO  out  1 each  result flags, driving the ALU DivZI/sign/DivVI/DivHI inputs.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; RUN counts the enabled cycles.
REQ-013 SHALL accept START only in IDLE with EN=1; operands and OP are latched on that edge; START in RUN or DONE is ignored.
REQ-014 SHALL assert BUSY in RUN and DONE; DONE is high only in state DONE.
REQ-015 SHALL reach DONE on the 8th enabled cycle after acceptance for MUL and the 11th for DIV, with a counter loaded from package constants.
REQ-016 SHALL hold state, counter and partial results unchanged while EN=0, and extend DONE until EN=1.
REQ-017 MUL: {Y_OUT,A_OUT} = Y*A, unsigned 16-bit; SO=Y_OUT[7]; ZO=(Y_OUT==0); VO=0; HO=0.
REQ-018 DIV, ya={Y,A}: if Y < 2X, A_OUT=ya/X and Y_OUT=ya%X; otherwise A_OUT=255-(ya-512X)/(256-X) and Y_OUT=X+(ya-512X)%(256-X), truncated to 8 bits.
REQ-019 DIV flags: VO=(Y>=X); HO=(Y[3:0]>=X[3:0]); SO=A_OUT[7]; ZO=(A_OUT==0).
REQ-020 SHALL handle X=0 by the REQ-018 formula without a special case: the otherwise branch applies and there is no division by zero.
REQ-021 SHALL compute DIV iteratively, one quotient bit per RUN step; the final result is bit-exact to REQ-018.
REQ-022 SHALL keep Y_OUT, A_OUT and the flags stable from DONE until the next accepted START.

Reset
REQ-023 SHALL, when RST_N=0 at a CLK edge regardless of EN, enter IDLE; BUSY=0, DONE=0, Y_OUT=A_OUT=0, ZO=1, SO=VO=HO=0, counter=0.
REQ-024 SHALL abort any in-progress operation on reset with no DONE pulse.

Configuration
REQ-025 SHALL honour macro SPC700_MULDIV_FAST_EN: when defined, RUN lasts one enabled cycle for both ops and the results are computed combinationally; when undefined, REQ-015 latencies apply. Results and flags are identical in both modes.

Structure
REQ-026 SHALL place the MulDivOp_t enum and the MUL_CYCLES=8 and DIV_CYCLES=11 constants in package spc700.
REQ-027 SHALL contain one sub-module, spc700_div_step: a combinational single shift-compare-subtract step on a 17-bit remainder, instantiated once and iterated by the FSM.

Verification
REQ-028 SHALL check MUL Y=12 A=34 (hex) -> Y_OUT=03, A_OUT=A8, SO=0, ZO=0, DONE 8 EN-cycles after START.
REQ-029 SHALL check MUL FF*FF -> Y_OUT=FE, A_OUT=01, SO=1; and MUL 00*37 -> 0000, ZO=1.
REQ-030 SHALL check DIV Y=01 A=00 X=10 -> A_OUT=10, Y_OUT=00, VO=0, HO=1, ZO=0, DONE after 11 EN-cycles.
REQ-031 SHALL check DIV overflow Y=10 A=00 X=08 -> A_OUT=FF, Y_OUT=08, VO=1, HO=0, SO=1.
REQ-032 SHALL check DIV by zero Y=00 A=05 X=00 -> A_OUT=FF, Y_OUT=05, VO=1, HO=1.
REQ-033 SHALL check that EN toggling 50% during DIV leaves the results unchanged with DONE at the 11th enabled cycle, and that START during BUSY is ignored and RST_N low mid-RUN gives IDLE with no DONE.
